// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply sequencer and the future divide sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    LAUNCH  = 3'd2,
    RUN     = 3'd3,
    CAPTURE = 3'd4
  } seq_state_e;

  localparam int MULT_CYCLES_DEFAULT = 35;

endpackage

// File: rtl/hilo_sequencer.sv
// Sequences the iterative multiplier (clear, launch, fixed-latency wait, capture)
// and owns the architectural HI/LO registers, including mthi/mtlo writes.
module hilo_sequencer
  import muldiv_pkg::*;
#(
  parameter  int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  localparam int CNT_W       = $clog2(MULT_CYCLES + 1)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wr_data,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic        mult_clear,
  output logic        mult_enable,
  output logic        stall,
  output logic        done,
  output logic        conflict,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [31:0]      hi_q,    hi_d;
  logic [31:0]      lo_q,    lo_d;
  logic             is_idle;

  assign is_idle = (state_q == IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        // A start request takes priority over a same-cycle move-to write.
        if (start_mult) begin
          state_d = CLEAR;
        end else begin
          if (mthi) hi_d = wr_data;
          if (mtlo) lo_d = wr_data;
        end
      end
      CLEAR: begin
        cnt_d   = CNT_LOAD;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        state_d = RUN;
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CAPTURE: begin
        hi_d    = mult_hi;
        lo_d    = mult_lo;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes decode the registered state only, so they cannot glitch on inputs.
  assign mult_clear  = (state_q == CLEAR);
  assign mult_enable = (state_q == LAUNCH);
  assign done        = (state_q == CAPTURE);

  assign stall    = !is_idle || start_mult;
  assign conflict = is_idle ? (start_mult && (mthi || mtlo))
                            : (start_mult || mthi || mtlo);

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_hilo_sequencer.sv
// Directed bench for hilo_sequencer with a behavioural clear/launch multiplier model.
module tb_hilo_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_mult = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic        mult_clear;
  logic        mult_enable;
  logic        stall;
  logic        done;
  logic        conflict;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [63:0] prod_q = '0;

  hilo_sequencer #(.MULT_CYCLES(35)) dut (
    .clock       (clock),
    .reset       (reset),
    .start_mult  (start_mult),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .wr_data     (wr_data),
    .mult_hi     (mult_hi),
    .mult_lo     (mult_lo),
    .mult_clear  (mult_clear),
    .mult_enable (mult_enable),
    .stall       (stall),
    .done        (done),
    .conflict    (conflict),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clock = ~clock;

  // Multiplier model: clear zeroes the result, enable loads the signed product.
  always @(posedge clock) begin
    if (mult_clear)
      prod_q <= '0;
    else if (mult_enable)
      prod_q <= {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
  end
  assign mult_hi = prod_q[63:32];
  assign mult_lo = prod_q[31:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Cycle 0 is the current cycle; on return the bench sits in cycle 39 with
  // the results visible and no inputs asserted.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                         input logic with_mthi, input logic restart20,
                         input string name);
    int done_cnt = 0;
    op_a = a;
    op_b = b;
    for (int c = 0; c <= 39; c++) begin
      start_mult = (c == 0) || (restart20 && c == 20);
      mthi       = with_mthi && (c == 0);
      wr_data    = with_mthi ? 32'hAAAA5555 : 32'h0;
      #1;
      if (done) done_cnt++;
      chk($sformatf("%s stall c%0d", name, c), {31'b0, stall}, {31'b0, (c <= 38)});
      chk($sformatf("%s clear c%0d", name, c), {31'b0, mult_clear}, {31'b0, (c == 1)});
      chk($sformatf("%s enable c%0d", name, c), {31'b0, mult_enable}, {31'b0, (c == 2)});
      chk($sformatf("%s done c%0d", name, c), {31'b0, done}, {31'b0, (c == 38)});
      if (c == 0)
        chk($sformatf("%s conflict c0", name), {31'b0, conflict}, {31'b0, with_mthi});
      if (c == 20)
        chk($sformatf("%s conflict c20", name), {31'b0, conflict}, {31'b0, restart20});
      if (c >= 1 && c <= 38) begin
        chk($sformatf("%s hi hold c%0d", name, c), hi, prev_hi);
        chk($sformatf("%s lo hold c%0d", name, c), lo, prev_lo);
      end
      if (c < 39) begin
        step();
      end
    end
    start_mult = 1'b0;
    mthi       = 1'b0;
    chk($sformatf("%s hi result", name), hi, exp_hi);
    chk($sformatf("%s lo result", name), lo, exp_lo);
    chk($sformatf("%s done count", name), done_cnt, 32'd1);
    $display("mult %s: a=%h b=%h hi=%h lo=%h done_pulses=%0d", name, a, b, hi, lo, done_cnt);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    chk("rst stall", {31'b0, stall}, 32'h0);
    chk("rst done", {31'b0, done}, 32'h0);
    chk("rst clear", {31'b0, mult_clear}, 32'h0);
    chk("rst enable", {31'b0, mult_enable}, 32'h0);
    chk("rst conflict", {31'b0, conflict}, 32'h0);
    $display("reset: hi=%h lo=%h stall=%b", hi, lo, stall);
    step();
    step();
    reset = 1'b1;
    step();

    // mthi then mtlo in IDLE
    mthi = 1'b1; wr_data = 32'hDEADBEEF; #1;
    chk("mthi stall", {31'b0, stall}, 32'h0);
    chk("mthi conflict", {31'b0, conflict}, 32'h0);
    step();
    mthi = 1'b0;
    chk("mthi hi", hi, 32'hDEADBEEF);
    chk("mthi lo", lo, 32'h0);
    $display("mthi: hi=%h lo=%h", hi, lo);
    mtlo = 1'b1; wr_data = 32'h12345678; #1;
    chk("mtlo stall", {31'b0, stall}, 32'h0);
    chk("mtlo conflict", {31'b0, conflict}, 32'h0);
    step();
    mtlo = 1'b0;
    chk("mtlo hi", hi, 32'hDEADBEEF);
    chk("mtlo lo", lo, 32'h12345678);
    $display("mtlo: hi=%h lo=%h", hi, lo);

    // mthi and mtlo together
    mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h0BADF00D;
    step();
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthilo hi", hi, 32'h0BADF00D);
    chk("mthilo lo", lo, 32'h0BADF00D);
    $display("mthi+mtlo: hi=%h lo=%h", hi, lo);

    // 3 * -5
    do_mult(32'd3, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1,
            32'h0BADF00D, 32'h0BADF00D, 1'b0, 1'b0, "3x-5");

    // max positive squared, back to back
    do_mult(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001,
            32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0, "max1");
    do_mult(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001,
            32'h3FFFFFFF, 32'h00000001, 1'b0, 1'b0, "max2");

    // start with mthi in the same cycle: write dropped
    do_mult(32'd3, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1,
            32'h3FFFFFFF, 32'h00000001, 1'b1, 1'b0, "start+mthi");

    // second start mid-RUN is ignored
    do_mult(32'd7, 32'd6, 32'h0, 32'd42,
            32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b1, "restart20");

    // mtlo while busy is ignored and flagged
    step();
    op_a = 32'd2; op_b = 32'd9;
    start_mult = 1'b1; #1;
    step();
    start_mult = 1'b0;
    mtlo = 1'b1; wr_data = 32'h55555555; #1;
    chk("busy mtlo conflict", {31'b0, conflict}, 32'h1);
    step();
    mtlo = 1'b0;
    chk("busy mtlo lo", lo, 32'd42);

    // asynchronous reset in RUN (cycle 10)
    for (int c = 2; c < 10; c++) step();
    chk("pre-rst stall", {31'b0, stall}, 32'h1);
    reset = 1'b0; #1;
    chk("midrst stall", {31'b0, stall}, 32'h0);
    chk("midrst hi", hi, 32'h0);
    chk("midrst lo", lo, 32'h0);
    chk("midrst enable", {31'b0, mult_enable}, 32'h0);
    $display("mid-run reset: stall=%b hi=%h lo=%h", stall, hi, lo);
    step();
    reset = 1'b1;
    step();
    chk("postrst done", {31'b0, done}, 32'h0);
    do_mult(32'd3, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1,
            32'h0, 32'h0, 1'b0, 1'b0, "after-rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
